// File: rtl/msm_pipe_pkg.sv
// Shared limits and helpers for the msm pipeline blocks.
// Holds the legal DEPTH/WIDTH ranges and the occupancy-counter width function.
package msm_pipe_pkg;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 1024;
    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 32;

    // Bits needed to hold an occupancy count of 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/elastic_stage.sv
// One elastic register stage: valid flop, data flop, advance logic; data reset under ELASTIC_PIPE_DATA_RST_EN.
// Latency: 1 cycle per stage.
// Backpressure: in_rdy = empty or advancing, combinational from out_rdy.
module elastic_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             in_rdy,
    input  logic             out_rdy,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat
);

    (* shreg_extract = "no" *) logic             vld_q;
    (* shreg_extract = "no" *) logic [WIDTH-1:0] dat_q;
    logic load;

    assign in_rdy  = !vld_q || out_rdy;
    assign load    = in_vld && in_rdy && !flush;
    assign out_vld = vld_q;
    assign out_dat = dat_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_q <= 1'b0;
        end else if (in_rdy) begin
            vld_q <= in_vld;
        end
    end

`ifdef ELASTIC_PIPE_DATA_RST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dat_q <= '0;
        end else if (load) begin
            dat_q <= in_dat;
        end
    end
`else
    // Payload flops carry no reset; only valid bits define pipe state.
    always_ff @(posedge clk) begin
        if (load) begin
            dat_q <= in_dat;
        end
    end
`endif

endmodule

// File: rtl/elastic_pipe.sv
// Valid/ready pipe of DEPTH bubble-collapsing stages with flush and occupancy count; ELASTIC_PIPE_DATA_RST_EN resets data.
// Latency: DEPTH cycles on an empty, unstalled pipe; one beat per cycle throughput.
// Backpressure: ready_o ripples combinationally from ready_i; forced low during flush_i.
module elastic_pipe
    import msm_pipe_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       valid_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           data_o,
    input  logic                       ready_i,
    output logic [cnt_w(DEPTH)-1:0]    count_o
);

    localparam int CW = cnt_w(DEPTH);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX || WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_param
        $error("elastic_pipe: DEPTH or WIDTH outside legal range");
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             s_vld;
        logic [WIDTH-1:0] s_dat;
        logic             s_rdy;
        logic             o_rdy;
        logic             o_vld;
        logic [WIDTH-1:0] o_dat;

        if (k == 0) begin : g_head
            assign s_vld = valid_i && !flush_i;
            assign s_dat = data_i;
        end else begin : g_body
            assign s_vld = g_stage[k-1].o_vld;
            assign s_dat = g_stage[k-1].o_dat;
        end

        if (k == DEPTH - 1) begin : g_tail
            assign s_rdy = ready_i;
        end else begin : g_link
            assign s_rdy = g_stage[k+1].o_rdy;
        end

        elastic_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush_i),
            .in_vld  (s_vld),
            .in_dat  (s_dat),
            .in_rdy  (o_rdy),
            .out_rdy (s_rdy),
            .out_vld (o_vld),
            .out_dat (o_dat)
        );
    end

    assign ready_o = g_stage[0].o_rdy && !flush_i;
    assign valid_o = g_stage[DEPTH-1].o_vld;
    assign data_o  = g_stage[DEPTH-1].o_dat;

    // Occupancy tracked incrementally; equals the sum of stage valids.
    (* shreg_extract = "no" *) logic [CW-1:0] count_q;
    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = valid_i && ready_o;
    assign out_xfer = valid_o && ready_i;
    assign count_o  = count_q;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CW'(in_xfer) - CW'(out_xfer);
        end
    end

endmodule

// File: doc/elastic_pipe.md
ELASTIC_PIPE -- requirements
Module: elastic_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 1: payload width in bits, legal range 1..1024.
REQ-002 SHALL have parameter DEPTH, default 1: number of register stages, legal range 1..32; DEPTH=0 fails elaboration.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port flush_i, input, 1 bit: synchronous clear of all stage valids.
REQ-006 SHALL have port valid_i, input, 1 bit: upstream beat present.
REQ-007 SHALL have port data_i, input, WIDTH bits: upstream payload.
REQ-008 SHALL have port ready_o, output, 1 bit: block accepts a beat this cycle.
REQ-009 SHALL have port valid_o, output, 1 bit: last stage holds a beat.
REQ-010 SHALL have port data_o, output, WIDTH bits: last-stage payload.
REQ-011 SHALL have port ready_i, input, 1 bit: downstream accepts the beat.
REQ-012 SHALL have port count_o, output, clog2(DEPTH+1) bits: number of occupied stages.

Function
REQ-013 SHALL hold one valid bit and one WIDTH-bit data register per stage, stage 0 at input and stage DEPTH-1 at output.
REQ-014 A transfer SHALL occur on any interface where valid and ready are both high at the rising edge; no other condition transfers.
REQ-015 Stage k SHALL advance when stage k+1 is empty or advancing; the last stage advances when ready_i=1.
REQ-016 Bubbles SHALL collapse: an empty stage accepts its predecessor's beat even while later stages stall.
REQ-017 ready_o SHALL be (stage 0 empty) OR (stage 0 advancing), derived combinationally from ready_i through the ready chain.
REQ-018 With ready_i held at 1 and an empty pipe, data accepted at edge N SHALL appear on data_o, with valid_o=1, after edge N+DEPTH-1; latency is DEPTH cycles, matching the existing one-stage pipe at DEPTH=1.
REQ-019 Throughput SHALL be one beat per cycle whenever ready_i=1.
REQ-020 A stalled stage's data register SHALL hold its value; data registers load only on transfer into them.
REQ-021 data_o and valid_o SHALL be stable while valid_o=1 and ready_i=0.
REQ-022 count_o SHALL equal the sum of stage valid bits, registered; full is count_o=DEPTH, at which point ready_o depends solely on ready_i.
REQ-023 flush_i=1 SHALL clear every stage valid at the edge, drop the beat on valid_i, and force ready_o=0 that cycle; count_o becomes 0.
REQ-024 A simultaneous output transfer and flush SHALL count as delivered downstream; the flush then clears the remaining stages.
REQ-025 Beat order SHALL be preserved; no beat duplicated or lost except by flush or reset.

Reset
REQ-026 rst=1 at an edge SHALL clear all valid bits; after reset valid_o=0, count_o=0, and ready_o=1.
REQ-027 Reset mid-operation SHALL discard all in-flight beats, with precedence over flush_i and transfers.
REQ-028 Without the Configuration macro, data_o and the data registers SHALL be unreset, starting X in simulation.

Configuration
REQ-029 Macro ELASTIC_PIPE_DATA_RST_EN defined: all data registers, including data_o, SHALL reset to 0 on rst.
REQ-030 Macro ELASTIC_PIPE_DATA_RST_EN undefined: data registers SHALL have no reset, valid bits only, for routing and area.

Structure
REQ-031 The shared package msm_pipe_pkg SHALL hold the DEPTH/WIDTH legal limits and the count-width function clog2(DEPTH+1).
REQ-032 One stage SHALL be the sub-module elastic_stage (valid flop, data flop, advance logic), instantiated DEPTH times via generate.
REQ-033 Every register SHALL carry the register-only SRL attribute so that no stage maps to SRL.

Verification
REQ-034 DEPTH=4, WIDTH=8, ready_i=1, inputs 0x01..0x08 on consecutive cycles -> data_o=0x01 four cycles after first accept, then one beat per cycle, in order.
REQ-035 DEPTH=4, ready_i=0, valid_i=1 for 6 cycles -> 4 beats accepted, count_o=4, ready_o=0; ready_i=1 for 1 cycle -> exactly one beat out, ready_o=1 the same cycle.
REQ-036 DEPTH=4, single beat 0xAA, then ready_i=0, then 0xBB one cycle later -> bubble collapses; count_o=2 with 0xAA and 0xBB adjacent in the last two stages.
REQ-037 Full pipe, flush_i=1 with valid_i=1 and ready_i=1 -> the output beat is delivered, the input beat is dropped, and count_o=0 and valid_o=0 next cycle.
REQ-038 rst asserted mid-stream with ELASTIC_PIPE_DATA_RST_EN defined -> next cycle valid_o=0, data_o=0, count_o=0, ready_o=1; without the macro, data_o is unchanged or X and valid_o=0.
REQ-039 Random valid_i/ready_i at 50% duty for 10k cycles, DEPTH in {1,2,7} -> scoreboard shows no loss, duplication or reorder, and data_o is stable under stall.
